d_cache_2way: RTL and testbench
===============================

# d_cache_2way

Parametrised 2-way set-associative, write-back, write-allocate byte data cache between the CPU data port and the SDRAM line interface. It generalises the current direct-mapped data cache with configurable address, index and line widths, per-line valid and dirty bits, LRU replacement, explicit request/acknowledge handshakes on both sides, and a flush that writes back only dirty lines.

## Interface
- ADDR_W, 16: CPU byte-address width.
- INDEX_W, 6: set-index width; 2^INDEX_W sets.
- OFFSET_W, 3: byte offset within a line; LINE_W = 8·2^OFFSET_W bits; TAG_W = ADDR_W−INDEX_W−OFFSET_W (≥1).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  flush request; sampled only when cpu_ready=1.
- flush_done  out  1  one-cycle pulse when flush completes.
- cpu_ren / cpu_wren  in  1 each  read / write request; mutually exclusive.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  8  write byte.
- cpu_ready  out  1  block accepts a request this cycle.
- cpu_ack  out  1  one-cycle pulse: request complete.
- cpu_rdata  out  8  read byte; valid when cpu_ack=1 for a read, holds otherwise.
- mem_req  out  1  memory transaction request; level, held until mem_ready.
- mem_wren  out  1  1 = line writeback, 0 = line fill; stable while mem_req=1.
- mem_addr  out  ADDR_W−OFFSET_W  line address; stable while mem_req=1.
- mem_wdata  out  LINE_W  writeback data; stable while mem_req=1.
- mem_rdata  in  LINE_W  fill data; valid in mem_ready cycle.
- mem_ready  in  1  one-cycle completion pulse.

## Operation
- Storage per set: 2 ways × {valid, dirty, tag, line}; one LRU bit per set (names the least-recently-used way). Data/tag arrays read synchronously.
- States: INIT, IDLE, LOOKUP, WB, FILL, FLUSH_RD, FLUSH_WB.
- INIT: clears valid, dirty, LRU of set k in cycle k; 2^INDEX_W cycles, then IDLE.
- IDLE: cpu_ready = ~flush. flush=1 → FLUSH_RD (any concurrent CPU request not accepted). Else request accepted when (cpu_ren|cpu_wren)&cpu_ready; addr/wdata/type registered → LOOKUP.
- LOOKUP: hit = valid & tag match in a way (at most one).
  - Read hit: cpu_rdata ← byte[offset]; cpu_ack; LRU ← other way; → IDLE.
  - Write hit: byte[offset] ← wdata; dirty ← 1; cpu_ack; LRU update; → IDLE.
  - Miss: victim = first invalid way (way 0 priority), else LRU way. Victim valid&dirty → WB, else → FILL.
- WB: mem_req=1, mem_wren=1, mem_addr={victim tag, index}, mem_wdata=victim line. On mem_ready → FILL.
- FILL: mem_req=1, mem_wren=0, mem_addr={req tag, index}. On mem_ready: victim ← mem_rdata, tag, valid=1, dirty=0 → LOOKUP (re-lookup now hits; write merges there).
- FLUSH_RD: scan set s, way w from (0,0) to (2^INDEX_W−1,1), index-major. valid&dirty → FLUSH_WB, else clear valid and advance. After last entry: flush_done pulse, LRU all 0, → IDLE.
- FLUSH_WB: writeback as WB; on mem_ready clear valid/dirty, advance → FLUSH_RD.
- Address split: offset = addr[OFFSET_W−1:0], index = addr[OFFSET_W+INDEX_W−1:OFFSET_W], tag = upper TAG_W bits.

## Timing
- Reset values: cpu_ready=0, cpu_ack=0, cpu_rdata=0, mem_req=0, mem_wren=0, mem_addr=0, flush_done=0; state INIT.
- rst mid-operation (any state): abandons transaction, mem_req=0 from next cycle, no ack, full INIT rerun. A mem_ready arriving during INIT is ignored.
- Hit: accepted cycle N, cpu_ack at N+1, cpu_ready again at N+2.
- Clean miss: mem_req rises N+2; mem_ready at cycle M → cpu_ack at M+2.
- Dirty miss: writeback then fill, back-to-back; mem_req drops for exactly one cycle between them.
- mem_req deasserts the cycle after mem_ready; mem_ready while mem_req=0 is ignored.
- Flush of D dirty lines: 2·2^INDEX_W scan cycles plus D memory transactions; cpu_ready=0 throughout.

## Test plan
- Reset: rst 1 cycle → cpu_ready=0 for 64 cycles, then 1; all reads miss; mem_req=0 during INIT.
- Read miss/hit: read 0x1234, mem_rdata=0x8877665544332211 → fill addr 0x246, cpu_rdata=0x55 (offset 4); read 0x1230 → ack next cycle, rdata=0x11, no mem_req.
- Write allocate + eviction: write 0xAB to 0x0000 (miss, fill), read 0x4000 and 0x8000 (same set) → third access evicts way of 0x0000; writeback mem_addr=0x000, byte 0 of mem_wdata=0xAB, then fill 0x1000.
- LRU: fill 0x0000, 0x4000, read 0x0000, access 0x8000 → 0x4000 evicted (clean, no writeback); 0x0000 still hits.
- Flush: dirty lines at 0x0008 and 0xC1F8 → exactly two writebacks, addrs 0x001 then 0x183F, flush_done once, subsequent read 0x0008 misses; flush and cpu_ren same cycle → request not accepted.
- Reset mid-fill: rst while mem_req=1 in FILL → mem_req=0 next cycle, no cpu_ack, INIT reruns.

Source files
------------

// File: rtl/d_cache_2way.sv
// 2-way set-associative, write-back, write-allocate byte data cache sitting
// between the CPU data port and the SDRAM line interface. Each set has one
// LRU bit, and each way has valid, dirty, tag and line storage.
// A flush writes back only the dirty lines and then invalidates the cache.
`timescale 1ns/1ps

module d_cache_2way #(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    output logic                        flush_done,
    input  logic                        cpu_ren,
    input  logic                        cpu_wren,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [7:0]                  cpu_wdata,
    output logic                        cpu_ready,
    output logic                        cpu_ack,
    output logic [7:0]                  cpu_rdata,
    output logic                        mem_req,
    output logic                        mem_wren,
    output logic [ADDR_W-OFFSET_W-1:0]  mem_addr,
    output logic [(8<<OFFSET_W)-1:0]    mem_wdata,
    input  logic [(8<<OFFSET_W)-1:0]    mem_rdata,
    input  logic                        mem_ready
);

    localparam int LINE_W  = 8 << OFFSET_W;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS    = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_FLUSH_RD,
        S_FLUSH_WB
    } state_t;

    // Storage arrays
    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     lru_q;
    logic [TAG_W-1:0]    tag_q   [2][SETS];
    logic [LINE_W-1:0]   line_q  [2][SETS];

    // Synchronous read port: both ways of the addressed set, one cycle later
    logic [1:0]          rd_valid_q;
    logic [1:0]          rd_dirty_q;
    logic [TAG_W-1:0]    rd_tag_q  [2];
    logic [LINE_W-1:0]   rd_line_q [2];

    // Control and request registers
    state_t              state_q;
    logic [INDEX_W-1:0]  init_cnt_q;
    logic [INDEX_W:0]    fl_ptr_q;      // {set, way}; way is the LSB so the scan is index-major
    logic [ADDR_W-1:0]   req_addr_q;
    logic [7:0]          req_wdata_q;
    logic                req_wr_q;
    logic                relook_q;      // read port still holds pre-fill contents
    logic                victim_q;
    logic [7:0]          rdata_q;
    logic                flush_done_q;
    logic                mem_req_q;
    logic                mem_wren_q;
    logic [ADDR_W-OFFSET_W-1:0] mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    // Combinational helpers
    logic [OFFSET_W-1:0] req_off;
    logic [INDEX_W-1:0]  req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  rd_idx;
    logic                hit0, hit1, hit, hit_way;
    logic                lookup_eval;
    logic [LINE_W-1:0]   hit_line;
    logic [LINE_W-1:0]   merged_line;
    logic [7:0]          hit_byte;
    logic                victim;
    logic                victim_dirty;
    logic [INDEX_W-1:0]  fl_idx;
    logic                fl_way;
    logic                fl_last;
    logic                fl_dirty;

    assign req_off = req_addr_q[OFFSET_W-1:0];
    assign req_idx = req_addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];

    // The read port follows the incoming address while idle and the held request otherwise.
    assign rd_idx = (state_q == S_IDLE) ? cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W] : req_idx;

    assign hit0        = rd_valid_q[0] && (rd_tag_q[0] == req_tag);
    assign hit1        = rd_valid_q[1] && (rd_tag_q[1] == req_tag);
    assign hit         = hit0 || hit1;
    assign hit_way     = hit1;
    assign lookup_eval = (state_q == S_LOOKUP) && !relook_q;

    assign fl_idx   = fl_ptr_q[INDEX_W:1];
    assign fl_way   = fl_ptr_q[0];
    assign fl_last  = &fl_ptr_q;
    assign fl_dirty = valid_q[fl_way][fl_idx] && dirty_q[fl_way][fl_idx];

    // Hit line selection and the byte merge for write hits
    always_comb begin
        hit_line = hit_way ? rd_line_q[1] : rd_line_q[0];
        hit_byte = hit_line[{req_off, 3'b000} +: 8];
        merged_line = hit_line;
        merged_line[{req_off, 3'b000} +: 8] = req_wdata_q;
    end

    // Victim choice: first invalid way (way 0 first), otherwise the LRU way
    always_comb begin
        if (!rd_valid_q[0]) begin
            victim = 1'b0;
        end else if (!rd_valid_q[1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[req_idx];
        end
        victim_dirty = rd_valid_q[victim] && rd_dirty_q[victim];
    end

    assign cpu_ready  = (state_q == S_IDLE) && !flush;
    assign cpu_ack    = lookup_eval && hit;
    // Read data is valid during the ack cycle and holds the last read byte otherwise.
    assign cpu_rdata  = (cpu_ack && !req_wr_q) ? hit_byte : rdata_q;
    assign flush_done = flush_done_q;
    assign mem_req    = mem_req_q;
    assign mem_wren   = mem_wren_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // Cache controller FSM together with the array and read-port updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            fl_ptr_q     <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wr_q     <= 1'b0;
            relook_q     <= 1'b0;
            victim_q     <= 1'b0;
            rdata_q      <= '0;
            flush_done_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            flush_done_q <= 1'b0;

            rd_valid_q   <= {valid_q[1][rd_idx], valid_q[0][rd_idx]};
            rd_dirty_q   <= {dirty_q[1][rd_idx], dirty_q[0][rd_idx]};
            rd_tag_q[0]  <= tag_q[0][rd_idx];
            rd_tag_q[1]  <= tag_q[1][rd_idx];
            rd_line_q[0] <= line_q[0][rd_idx];
            rd_line_q[1] <= line_q[1][rd_idx];

            case (state_q)
                S_INIT: begin
                    valid_q[0][init_cnt_q] <= 1'b0;
                    valid_q[1][init_cnt_q] <= 1'b0;
                    dirty_q[0][init_cnt_q] <= 1'b0;
                    dirty_q[1][init_cnt_q] <= 1'b0;
                    lru_q[init_cnt_q]      <= 1'b0;
                    init_cnt_q             <= init_cnt_q + INDEX_W'(1);
                    if (&init_cnt_q) begin
                        state_q <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (flush) begin
                        fl_ptr_q <= '0;
                        state_q  <= S_FLUSH_RD;
                    end else if (cpu_ren || cpu_wren) begin
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                        req_wr_q    <= cpu_wren;
                        relook_q    <= 1'b0;
                        state_q     <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (relook_q) begin
                        relook_q <= 1'b0;
                    end else if (hit) begin
                        lru_q[req_idx] <= ~hit_way;
                        if (req_wr_q) begin
                            line_q[hit_way][req_idx]  <= merged_line;
                            dirty_q[hit_way][req_idx] <= 1'b1;
                        end else begin
                            rdata_q <= hit_byte;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        victim_q  <= victim;
                        mem_req_q <= 1'b1;
                        if (victim_dirty) begin
                            mem_wren_q  <= 1'b1;
                            mem_addr_q  <= {rd_tag_q[victim], req_idx};
                            mem_wdata_q <= rd_line_q[victim];
                            state_q     <= S_WB;
                        end else begin
                            mem_wren_q <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx};
                            state_q    <= S_FILL;
                        end
                    end
                end

                S_WB: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_FILL;
                    end
                end

                // Entered either with the fill already requested (clean miss) or
                // straight after a writeback, in which case the request is issued here.
                S_FILL: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_wren_q <= 1'b0;
                        mem_addr_q <= {req_tag, req_idx};
                    end else if (mem_ready) begin
                        line_q[victim_q][req_idx]  <= mem_rdata;
                        tag_q[victim_q][req_idx]   <= req_tag;
                        valid_q[victim_q][req_idx] <= 1'b1;
                        dirty_q[victim_q][req_idx] <= 1'b0;
                        mem_req_q                  <= 1'b0;
                        relook_q                   <= 1'b1;
                        state_q                    <= S_LOOKUP;
                    end
                end

                S_FLUSH_RD: begin
                    if (fl_dirty) begin
                        mem_req_q   <= 1'b1;
                        mem_wren_q  <= 1'b1;
                        mem_addr_q  <= {tag_q[fl_way][fl_idx], fl_idx};
                        mem_wdata_q <= line_q[fl_way][fl_idx];
                        state_q     <= S_FLUSH_WB;
                    end else begin
                        valid_q[fl_way][fl_idx] <= 1'b0;
                        if (fl_last) begin
                            flush_done_q <= 1'b1;
                            lru_q        <= '0;
                            state_q      <= S_IDLE;
                        end else begin
                            fl_ptr_q <= fl_ptr_q + (INDEX_W+1)'(1);
                        end
                    end
                end

                S_FLUSH_WB: begin
                    if (mem_ready) begin
                        mem_req_q               <= 1'b0;
                        valid_q[fl_way][fl_idx] <= 1'b0;
                        dirty_q[fl_way][fl_idx] <= 1'b0;
                        if (fl_last) begin
                            flush_done_q <= 1'b1;
                            lru_q        <= '0;
                            state_q      <= S_IDLE;
                        end else begin
                            fl_ptr_q <= fl_ptr_q + (INDEX_W+1)'(1);
                            state_q  <= S_FLUSH_RD;
                        end
                    end
                end

                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_2way.sv
// Directed testbench for d_cache_2way. A small memory responder acknowledges
// each memory request two cycles after it first sees it and logs every
// transaction. Expected values are hand-computed for the default geometry:
// 16-bit addresses, 64 sets and 8-byte lines.
`timescale 1ns/1ps

module tb_d_cache_2way;

    localparam int ADDR_W   = 16;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 3;
    localparam int LINE_W   = 64;
    localparam int LADDR_W  = ADDR_W - OFFSET_W;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               flush_done;
    logic               cpu_ren;
    logic               cpu_wren;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [7:0]         cpu_wdata;
    logic               cpu_ready;
    logic               cpu_ack;
    logic [7:0]         cpu_rdata;
    logic               mem_req;
    logic               mem_wren;
    logic [LADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory responder state and transaction log
    logic               resp_en = 1'b1;
    logic               inject_ready = 1'b0;
    logic [LINE_W-1:0]  fill_data = '0;
    int                 cyc;
    int                 wait_c;
    logic               prev_req;
    int                 txn_cnt = 0;
    logic               txn_wren  [8];
    logic [LADDR_W-1:0] txn_addr  [8];
    logic [LINE_W-1:0]  txn_wdata [8];
    int                 txn_rise  [8];
    int                 txn_done  [8];

    d_cache_2way #(
        .ADDR_W   (ADDR_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_done (flush_done),
        .cpu_ren    (cpu_ren),
        .cpu_wren   (cpu_wren),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_req    (mem_req),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder: a pulse on mem_ready two cycles after the request is first seen
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        cyc       = 0;
        wait_c    = 0;
        prev_req  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_ready = inject_ready;
            if (mem_req && !prev_req && txn_cnt < 8) txn_rise[txn_cnt] = cyc;
            prev_req = mem_req;
            if (mem_req && resp_en && !rst) begin
                if (wait_c == 2) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_wren ? '0 : fill_data;
                    if (txn_cnt < 8) begin
                        txn_wren[txn_cnt]  = mem_wren;
                        txn_addr[txn_cnt]  = mem_addr;
                        txn_wdata[txn_cnt] = mem_wdata;
                        txn_done[txn_cnt]  = cyc;
                    end
                    txn_cnt++;
                    wait_c = 0;
                end else begin
                    wait_c++;
                end
            end else begin
                wait_c = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One CPU access. lat is the number of cycles from acceptance to ack
    // (1 for a hit); rdy is cpu_ready in the cycle after the ack.
    task automatic access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output logic rdy);
        int n;
        n = 0;
        while (!cpu_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        txn_cnt   = 0;
        cpu_ren   = !wr;
        cpu_wren  = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clk);
        cpu_ren  = 1'b0;
        cpu_wren = 1'b0;
        lat = 1;
        while (!cpu_ack && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rd = cpu_rdata;
        @(negedge clk);
        rdy = cpu_ready;
    endtask

    // Count cycles from the current negedge until cpu_ready rises
    task automatic wait_init(output int n, output int req_seen, output int ack_seen);
        n = 0;
        req_seen = 0;
        ack_seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) inject_ready = 1'b0;
            if (mem_req) req_seen++;
            if (cpu_ack) ack_seen++;
        end while (!cpu_ready && n < 200);
    endtask

    logic [7:0] rd;
    int         lat;
    logic       rdy;
    int         n_init, req_seen, ack_seen;
    int         done_n, ack_n, rdy_n, extra, k;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        cpu_ren   = 1'b0;
        cpu_wren  = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready",  64'(cpu_ready),  64'h0);
        chk("rst_cpu_ack",    64'(cpu_ack),    64'h0);
        chk("rst_cpu_rdata",  64'(cpu_rdata),  64'h0);
        chk("rst_mem_req",    64'(mem_req),    64'h0);
        chk("rst_mem_wren",   64'(mem_wren),   64'h0);
        chk("rst_mem_addr",   64'(mem_addr),   64'h0);
        chk("rst_flush_done", 64'(flush_done), 64'h0);
        rst = 1'b0;
        wait_init(n_init, req_seen, ack_seen);
        chk("init_cycles",   64'(n_init),   64'd64);
        chk("init_mem_req",  64'(req_seen), 64'd0);

        // Read miss then a hit in the same line
        fill_data = 64'h8877665544332211;
        access(1'b0, 16'h1234, 8'h00, rd, lat, rdy);
        chk("rmiss_rdata",   64'(rd),          64'h55);
        chk("rmiss_lat",     64'(lat),         64'd6);
        chk("rmiss_txns",    64'(txn_cnt),     64'd1);
        chk("rmiss_wren",    64'(txn_wren[0]), 64'h0);
        chk("rmiss_addr",    64'(txn_addr[0]), 64'h246);
        chk("rmiss_ready",   64'(rdy),         64'h1);
        access(1'b0, 16'h1230, 8'h00, rd, lat, rdy);
        chk("rhit_rdata",    64'(rd),          64'h11);
        chk("rhit_lat",      64'(lat),         64'd1);
        chk("rhit_txns",     64'(txn_cnt),     64'd0);
        chk("rhit_ready",    64'(rdy),         64'h1);

        // Write allocate into set 0, fill the second way, then evict the dirty line
        fill_data = 64'h1111111111111111;
        access(1'b1, 16'h0000, 8'hAB, rd, lat, rdy);
        chk("wmiss_lat",     64'(lat),         64'd6);
        chk("wmiss_txns",    64'(txn_cnt),     64'd1);
        chk("wmiss_wren",    64'(txn_wren[0]), 64'h0);
        chk("wmiss_addr",    64'(txn_addr[0]), 64'h000);
        chk("wmiss_rdata_hold", 64'(rd),       64'h11);
        fill_data = 64'h4444444444444444;
        access(1'b0, 16'h4000, 8'h00, rd, lat, rdy);
        chk("way1_rdata",    64'(rd),          64'h44);
        chk("way1_lat",      64'(lat),         64'd6);
        chk("way1_addr",     64'(txn_addr[0]), 64'h800);
        fill_data = 64'h0F0E0D0C0B0A0908;
        access(1'b0, 16'h8000, 8'h00, rd, lat, rdy);
        chk("evict_rdata",   64'(rd),          64'h08);
        chk("evict_lat",     64'(lat),         64'd10);
        chk("evict_txns",    64'(txn_cnt),     64'd2);
        chk("evict_wb_wren", 64'(txn_wren[0]), 64'h1);
        chk("evict_wb_addr", 64'(txn_addr[0]), 64'h000);
        chk("evict_wb_data", txn_wdata[0],     64'h11111111111111AB);
        chk("evict_fl_wren", 64'(txn_wren[1]), 64'h0);
        chk("evict_fl_addr", 64'(txn_addr[1]), 64'h1000);
        chk("evict_gap",     64'(txn_rise[1] - txn_done[0]), 64'd2);
        access(1'b0, 16'h4000, 8'h00, rd, lat, rdy);
        chk("way1_kept_lat", 64'(lat),         64'd1);
        chk("way1_kept_rd",  64'(rd),          64'h44);

        // LRU: the way touched least recently is the one replaced (set 2)
        fill_data = 64'h00000000000000A1;
        access(1'b0, 16'h0010, 8'h00, rd, lat, rdy);
        chk("lru_a_rd",      64'(rd),          64'hA1);
        fill_data = 64'h00000000000000B2;
        access(1'b0, 16'h4010, 8'h00, rd, lat, rdy);
        chk("lru_b_rd",      64'(rd),          64'hB2);
        chk("lru_b_addr",    64'(txn_addr[0]), 64'h802);
        access(1'b0, 16'h0010, 8'h00, rd, lat, rdy);
        chk("lru_a_hit_lat", 64'(lat),         64'd1);
        fill_data = 64'h00000000000000C3;
        access(1'b0, 16'h8010, 8'h00, rd, lat, rdy);
        chk("lru_c_rd",      64'(rd),          64'hC3);
        chk("lru_c_lat",     64'(lat),         64'd6);
        chk("lru_c_txns",    64'(txn_cnt),     64'd1);
        chk("lru_c_wren",    64'(txn_wren[0]), 64'h0);
        chk("lru_c_addr",    64'(txn_addr[0]), 64'h1002);
        access(1'b0, 16'h0010, 8'h00, rd, lat, rdy);
        chk("lru_a_kept_lat", 64'(lat),        64'd1);
        chk("lru_a_kept_rd",  64'(rd),         64'hA1);
        fill_data = 64'h00000000000000B2;
        access(1'b0, 16'h4010, 8'h00, rd, lat, rdy);
        chk("lru_b_gone_lat", 64'(lat),        64'd6);

        // Flush with two dirty lines (set 1 and set 63)
        fill_data = 64'h2222222222222222;
        access(1'b1, 16'h0008, 8'h5A, rd, lat, rdy);
        chk("fl_w1_lat",     64'(lat),         64'd6);
        fill_data = 64'h3333333333333333;
        access(1'b1, 16'hC1F8, 8'h77, rd, lat, rdy);
        chk("fl_w2_lat",     64'(lat),         64'd6);
        chk("fl_w2_addr",    64'(txn_addr[0]), 64'h183F);
        txn_cnt  = 0;
        flush    = 1'b1;
        cpu_ren  = 1'b1;
        cpu_addr = 16'h1230;
        #1;
        chk("fl_ready_low",  64'(cpu_ready),   64'h0);
        @(negedge clk);
        flush   = 1'b0;
        cpu_ren = 1'b0;
        done_n = 0; ack_n = 0; rdy_n = 0; extra = 0; k = 0;
        while (k < 1000 && extra < 4) begin
            if (flush_done) done_n++;
            if (cpu_ack) ack_n++;
            if (done_n == 0 && cpu_ready) rdy_n++;
            if (done_n > 0) extra++;
            @(negedge clk);
            k++;
        end
        chk("fl_done_once",  64'(done_n),      64'd1);
        chk("fl_no_ack",     64'(ack_n),       64'd0);
        chk("fl_ready_zero", 64'(rdy_n),       64'd0);
        chk("fl_txns",       64'(txn_cnt),     64'd2);
        chk("fl_wren0",      64'(txn_wren[0]), 64'h1);
        chk("fl_addr0",      64'(txn_addr[0]), 64'h001);
        chk("fl_data0",      txn_wdata[0],     64'h222222222222225A);
        chk("fl_wren1",      64'(txn_wren[1]), 64'h1);
        chk("fl_addr1",      64'(txn_addr[1]), 64'h183F);
        chk("fl_data1",      txn_wdata[1],     64'h3333333333333377);
        fill_data = 64'h2222222222222222;
        access(1'b0, 16'h0008, 8'h00, rd, lat, rdy);
        chk("postfl_lat",    64'(lat),         64'd6);
        chk("postfl_rd",     64'(rd),          64'h22);
        chk("postfl_wren",   64'(txn_wren[0]), 64'h0);
        chk("postfl_addr",   64'(txn_addr[0]), 64'h001);

        // Reset while a fill is outstanding
        resp_en = 1'b0;
        k = 0;
        while (!cpu_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        txn_cnt  = 0;
        cpu_ren  = 1'b1;
        cpu_addr = 16'h2000;
        @(negedge clk);
        cpu_ren = 1'b0;
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mf_req_up",     64'(mem_req),     64'h1);
        chk("mf_is_fill",    64'(mem_wren),    64'h0);
        chk("mf_addr",       64'(mem_addr),    64'h400);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mf_req_drop",   64'(mem_req),     64'h0);
        chk("mf_no_ack",     64'(cpu_ack),     64'h0);
        resp_en      = 1'b1;
        inject_ready = 1'b1;
        wait_init(n_init, req_seen, ack_seen);
        inject_ready = 1'b0;
        chk("mf_init_cycles", 64'(n_init),     64'd64);
        chk("mf_init_req",    64'(req_seen),   64'd0);
        chk("mf_init_ack",    64'(ack_seen),   64'd0);
        fill_data = 64'h8877665544332211;
        access(1'b0, 16'h1230, 8'h00, rd, lat, rdy);
        chk("mf_reread_lat",  64'(lat),         64'd6);
        chk("mf_reread_rd",   64'(rd),          64'h11);
        chk("mf_reread_addr", 64'(txn_addr[0]), 64'h246);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
